// File: rtl/gsram_fifo_pkg.sv
// Shared constants and types for the dual-port-SRAM-backed FIFO controller.
// Consumed by gsram_fifo_ctrl (optional stats via GSRAM_FIFO_STATS_EN) and gsram_fifo_skid.
package gsram_fifo_pkg;

    localparam int unsigned DEF_ABITS = 10;
    localparam int unsigned DEF_DBITS = 16;
    localparam int unsigned OB_DEPTH  = 2;

    // Output-buffer occupancy: 0, 1 or 2 entries.
    typedef logic [1:0] ob_cnt_t;

endpackage

// File: rtl/gsram_fifo_skid.sv
// Two-entry output skid buffer for the SRAM FIFO; absorbs read data already in flight.
module gsram_fifo_skid
    import gsram_fifo_pkg::*;
#(
    parameter int unsigned DBITS = DEF_DBITS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [DBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output ob_cnt_t          count
);

    logic [DBITS-1:0] mem [OB_DEPTH];
    logic             head;
    logic             wr_idx;

    // At count 2 the write lands in the head slot, which is only legal alongside a pop.
    assign wr_idx = head ^ count[0];
    assign dout   = mem[head];

    always_ff @(posedge CLK) begin
        if (RST) begin
            head   <= 1'b0;
            count  <= '0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= din;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gsram_fifo_ctrl.sv
// FIFO controller driving a dual-port SRAM (port 0 write, port 1 read, 1-cycle read latency).
// Define GSRAM_FIFO_STATS_EN to add the level / hwm occupancy outputs.
module gsram_fifo_ctrl
    import gsram_fifo_pkg::*;
#(
    parameter int unsigned ABITS = DEF_ABITS,
    parameter int unsigned DBITS = DEF_DBITS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DBITS-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DBITS-1:0] out_data,
    output logic [ABITS-1:0] A0,
    output logic [DBITS-1:0] D0,
    output logic             WE0,
    output logic             CE0,
    output logic [ABITS-1:0] A1,
    output logic [DBITS-1:0] D1,
    output logic             WE1,
    output logic             CE1,
    input  logic [DBITS-1:0] Q1
`ifdef GSRAM_FIFO_STATS_EN
    ,
    output logic [ABITS+1:0] level,
    output logic [ABITS+1:0] hwm
`endif
);

    localparam logic [ABITS:0] CNT_FULL = {1'b1, {ABITS{1'b0}}};

    logic [ABITS-1:0] wp;
    logic [ABITS-1:0] rp;
    logic [ABITS:0]   cnt;
    logic             inflight;
    ob_cnt_t          ob_count;

    logic             push_c;
    logic             pop_c;
    logic             rd_c;
    logic [2:0]       occ_c;

    // cnt only counts words still in SRAM, so a push is never read back in its own cycle.
    assign in_ready = !RST && (cnt < CNT_FULL);
    assign push_c   = in_valid && in_ready;
    assign pop_c    = out_valid && out_ready;

    // Issue a read only if the skid buffer can still hold it when it returns next cycle.
    assign occ_c = 3'(ob_count) + 3'(inflight);
    assign rd_c  = !RST && (cnt != '0) && (occ_c < (3'd2 + 3'(pop_c)));

    assign CE0 = push_c;
    assign WE0 = push_c;
    assign A0  = RST ? '0 : wp;
    assign D0  = in_data;

    assign CE1 = rd_c;
    assign WE1 = 1'b0;
    assign A1  = RST ? '0 : rp;
    assign D1  = '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            if (push_c) begin
                wp <= wp + ABITS'(1);
            end
            if (rd_c) begin
                rp <= rp + ABITS'(1);
            end
            inflight <= rd_c;
            case ({push_c, rd_c})
                2'b10:   cnt <= cnt + (ABITS+1)'(1);
                2'b01:   cnt <= cnt - (ABITS+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    gsram_fifo_skid #(
        .DBITS (DBITS)
    ) u_skid (
        .CLK   (CLK),
        .RST   (RST),
        .push  (inflight),
        .pop   (pop_c),
        .din   (Q1),
        .dout  (out_data),
        .count (ob_count)
    );

    assign out_valid = (ob_count != '0);

`ifdef GSRAM_FIFO_STATS_EN
    // Total words held anywhere: SRAM, read pipeline and skid buffer.
    assign level = (ABITS+2)'(cnt) + (ABITS+2)'(ob_count) + (ABITS+2)'(inflight);

    always_ff @(posedge CLK) begin
        if (RST) begin
            hwm <= '0;
        end else if (level > hwm) begin
            hwm <= level;
        end
    end
`endif

endmodule
